vga_fb_arbiter: RTL

- Shares one single-port frame-buffer RAM between two requesters: the VGA scan-out path (pixel reads) and a writer (pattern engine or host).
- Sits between the pixel-timing/pattern logic and the frame-buffer RAM, and runs in the pixel_clk domain.
- Display reads have strict priority, so scan-out never loses a pixel.
- Writes are granted in idle cycles, or optionally only during vertical blank for tear-free updates. A starvation monitor flags writers that are blocked too long.

---
 rtl/vga_fb_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares one single-port frame-buffer RAM between the VGA scan-out path
// (pixel reads) and a writer (pattern engine or host). Everything runs in
// the pixel clock domain.
//
// Display reads always win, so scan-out never loses a pixel. The writer is
// served in cycles the display leaves idle. It can optionally be restricted
// to the vertical blanking interval for tear-free updates. A starvation
// monitor raises a sticky flag when the writer has been blocked for too long.
//
// Parameters
//   ADDR_WIDTH   frame-buffer word address width
//   DATA_WIDTH   pixel word width (3 x RGB_WIDTH)
//   RD_LATENCY   RAM read latency, mem_en to mem_rdata (1..3)
//   STARVE_LIMIT consecutive blocked-writer cycles before wr_starved (>=2)
//
// Ports
//   pixel_clk       pixel clock, sole clock
//   reset           asynchronous active-high reset
//   disp_req        display needs a pixel read this cycle
//   disp_addr       display read address
//   disp_rvalid     disp_rdata is valid this cycle
//   disp_rdata      read pixel data (combinational from mem_rdata)
//   wr_valid        writer has a pending write
//   wr_ready        a write is accepted this cycle when wr_valid=1
//   wr_addr         write address
//   wr_data         write data
//   wr_vblank_only  1 = grant writes only while vblank=1
//   vblank          vertical blanking interval indicator
//   mem_en          RAM access enable (registered)
//   mem_we          RAM write enable (registered)
//   mem_addr        RAM address (registered)
//   mem_wdata       RAM write data (registered)
//   mem_rdata       RAM read data
//   wr_starved      sticky flag: writer blocked >= STARVE_LIMIT cycles
//   starve_clr      one-cycle pulse that clears wr_starved
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int ADDR_WIDTH   = 17,
  parameter int DATA_WIDTH   = 12,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic                  pixel_clk,
  input  logic                  reset,
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic                  disp_rvalid,
  output logic [DATA_WIDTH-1:0] disp_rdata,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_vblank_only,
  input  logic                  vblank,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wr_starved,
  input  logic                  starve_clr
);

  localparam int CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax   = CntW'(STARVE_LIMIT);
  localparam logic [CntW-1:0] StarveMaxM1 = CntW'(STARVE_LIMIT - 1);

  logic                  dispGrant;
  logic                  writeWindow;
  logic                  wrGrant;
  logic                  wrBlocked;

  logic                  memEn_q,    memEn_d;
  logic                  memWe_q,    memWe_d;
  logic [ADDR_WIDTH-1:0] memAddr_q,  memAddr_d;
  logic [DATA_WIDTH-1:0] memWdata_q, memWdata_d;

  logic [RD_LATENCY:0]   rvalidSr_q, rvalidSr_d;

  logic [CntW-1:0]       starveCnt_q, starveCnt_d;
  logic                  starved_q,   starved_d;
  logic                  starveSet;

  // Grant decision for the current cycle. The display has strict priority.
  // The writer's window depends only on the display request and the vblank
  // gating, never on wr_valid, so wr_ready can be shown to the writer before
  // it commits. While reset is held, nothing is accepted so that a pending
  // write is not silently consumed.
  always_comb begin
    dispGrant   = disp_req;
    writeWindow = ~disp_req & (~wr_vblank_only | vblank);
    wr_ready    = writeWindow & ~reset;
    wrGrant     = wr_valid & wr_ready;
    wrBlocked   = wr_valid & ~wr_ready;
  end

  // Next-state for the registered memory port. The grant seen in this cycle
  // drives the RAM in the next one. When idle, the address and data buses
  // keep their last values so they don't toggle needlessly. Only the enables
  // drop.
  always_comb begin
    memEn_d    = 1'b0;
    memWe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    if (dispGrant) begin
      memEn_d   = 1'b1;
      memAddr_d = disp_addr;
    end else if (wrGrant) begin
      memEn_d    = 1'b1;
      memWe_d    = 1'b1;
      memAddr_d  = wr_addr;
      memWdata_d = wr_data;
    end
  end

  // Read-valid tracking. Each display grant enters bit 0, which lines up with
  // the mem_en cycle. It then walks RD_LATENCY more stages to meet the data
  // coming back from the RAM. One bit per cycle gives full 1-read/cycle
  // throughput with no bubbles.
  always_comb begin
    rvalidSr_d = {rvalidSr_q[RD_LATENCY-1:0], dispGrant};
  end

  // Starvation monitor. The counter measures the current run of consecutive
  // blocked cycles. It restarts whenever the writer is served or withdraws
  // its request, and saturates at the limit. The flag is raised in the cycle
  // after the run reaches the limit. Once raised, it stays set until
  // software clears it. A fresh set outranks a simultaneous clear so that
  // an ongoing starvation event is never lost.
  always_comb begin
    starveCnt_d = '0;
    if (wrBlocked) begin
      if (starveCnt_q == StarveMax) begin
        starveCnt_d = starveCnt_q;
      end else begin
        starveCnt_d = starveCnt_q + 1'b1;
      end
    end
    starveSet = wrBlocked & (starveCnt_q >= StarveMaxM1);
    starved_d = starved_q;
    if (starveSet) begin
      starved_d = 1'b1;
    end else if (starve_clr) begin
      starved_d = 1'b0;
    end
  end

  // State registers. Reset drops every in-flight read and any staged access
  // immediately, so no late rvalid or stray write appears after release.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      memEn_q     <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      rvalidSr_q  <= '0;
      starveCnt_q <= '0;
      starved_q   <= 1'b0;
    end else begin
      memEn_q     <= memEn_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      rvalidSr_q  <= rvalidSr_d;
      starveCnt_q <= starveCnt_d;
      starved_q   <= starved_d;
    end
  end

  // Output mapping. Read data passes straight through from the RAM. It is
  // only meaningful while disp_rvalid is high.
  always_comb begin
    mem_en      = memEn_q;
    mem_we      = memWe_q;
    mem_addr    = memAddr_q;
    mem_wdata   = memWdata_q;
    disp_rvalid = rvalidSr_q[RD_LATENCY];
    disp_rdata  = mem_rdata;
    wr_starved  = starved_q;
  end

endmodule
